nn_layer_engine: RTL and testbench
==================================

Name: nn_layer_engine

Overview:
- Parametrised fully-connected layer engine: LANES MAC lanes, each processing one independent sample, all sharing one weight stream.
- An internal sequencer generates the input and weight SRAM read addresses. It accumulates, rounds, saturates and applies a selectable activation for each neuron, then hands one neuron's result for all lanes downstream per valid/ready transfer.
- Replaces hard-wired 10-lane MAC/sigmoid/mux chains. One instance is used per network layer.

Parameters:
DATA_W, 16, sample/weight/result width, signed fixed point
FRAC_W, 8, fractional bits (1.0 = 1<<FRAC_W)
LANES, 10, parallel sample lanes
IN_ADDR_W, 10, input SRAM address width (max inputs per neuron = 2^IN_ADDR_W)
N_ADDR_W, 7, neuron count/index width
W_ADDR_W, 18, weight SRAM address width
ACC_W, 42, accumulator width (2*DATA_W + IN_ADDR_W; no wrap possible)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
start  in  1  single-cycle start pulse; honoured only in IDLE
abort  in  1  synchronous abort; return to IDLE next edge
cfg_n_inputs  in  IN_ADDR_W+1  inputs per neuron, 1..2^IN_ADDR_W; latched at start
cfg_n_neurons  in  N_ADDR_W+1  neuron count, 1..2^N_ADDR_W; latched at start
cfg_act  in  2  activation: 0 identity, 1 ReLU, 2 hard-sigmoid, 3 identity
in_addr  out  IN_ADDR_W  input SRAM read address, shared by all lanes
w_addr  out  W_ADDR_W  weight SRAM read address
rd_en  out  1  read strobe for input and weight SRAMs
in_data  in  LANES*DATA_W  lane samples; lane k in bits [k*DATA_W +: DATA_W]; valid 1 cycle after rd_en
w_data  in  DATA_W  weight; valid 1 cycle after rd_en
out_data  out  LANES*DATA_W  activated results, same lane packing
out_neuron  out  N_ADDR_W  neuron index of out_data
out_valid  out  1  result valid
out_ready  in  1  downstream accepts when out_valid & out_ready
busy  out  1  high in all states except IDLE
done  out  1  one-cycle pulse after the last neuron is accepted

Behaviour:
- Reset: state IDLE; accumulators, in_addr, w_addr, out_data, out_neuron cleared to 0; rd_en, out_valid, busy, done low.
- IDLE --start--> RUN. On this edge: latch cfg_*, set i=0, j=0, w_addr=0, clear accumulators.
- RUN: rd_en=1, in_addr=i, w_addr increments every cycle (running counter; no multiply). Lasts n_inputs cycles, then TAIL.
- Accumulate rule: each cycle after an rd_en cycle, every lane adds sign-extended in_data[k]*w_data to acc[k].
- TAIL: 1 cycle, consumes the last read data. Then ACT.
- ACT: 1 cycle. For each lane:
  - r = (acc + (1<<(FRAC_W-1))) >>> FRAC_W, i.e. round half up.
  - Saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Apply activation:
    - ReLU: max(r,0).
    - Hard-sigmoid: clamp((r>>>2) + (1<<(FRAC_W-1)), 0, 1<<FRAC_W).
  - Register the result into out_data; out_neuron=j. Then OUT.
- Latency: out_valid rises n_inputs+2 cycles after entering RUN.
- OUT: out_valid=1; out_data and out_neuron held stable; no reads issued.
  - On out_valid & out_ready, if j < n_neurons-1: j++, i=0, clear accumulators, go to RUN. w_addr continues, so neuron j reads weights j*n_inputs .. j*n_inputs+n_inputs-1.
  - On out_valid & out_ready, if j is the last neuron: go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- start while busy: ignored, no effect on latched cfg.
- abort: takes priority over all transitions. Next edge: IDLE, rd_en=0, out_valid=0, no done pulse.
- Reset mid-operation: immediate asynchronous return to the reset state.
- cfg_n_inputs=0 or cfg_n_neurons=0: treated as 1.
- w_addr wraps modulo 2^W_ADDR_W.

Decomposition:
- Package nn_pkg holds:
  - activation codes ACT_IDENT/ACT_RELU/ACT_HSIG;
  - state encoding IDLE/RUN/TAIL/ACT/OUT/DONE;
  - default DATA_W/FRAC_W constants.
- Sub-module nn_act_unit, instantiated LANES times via generate: combinational round, saturate and activation from ACC_W to DATA_W.
- MAC accumulators and the sequencer stay in nn_layer_engine.

Test Plan:
- Identity: n_inputs=2, n_neurons=1, act=0. Lane0 x=[256,512], w=[256,128] -> out_data lane0=512, out_valid 4 cycles after RUN entry, done pulse after out_ready.
- ReLU/hard-sigmoid: single input, weight 256, x=-512 -> ReLU 0. Hard-sigmoid with x=0 -> 128, x=1024 -> 256 (clamped), x=-1024 -> 0.
- Saturation: n_inputs=4, x=32767, w=32767 all lanes, act=0 -> 32767 every lane. x=-32768, w=32767 -> -32768.
- Backpressure/addressing: n_inputs=3, n_neurons=3, out_ready low 5 cycles per result -> out_data stable, rd_en=0 while waiting, w_addr sequences 0..8 exactly once, out_neuron 0,1,2.
- Control: start pulsed during RUN -> ignored. abort in RUN -> IDLE next cycle, no done. reset asserted mid-ACT -> all outputs 0 asynchronously, then a fresh run gives correct results.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared definitions for the fully-connected layer engine: activation codes,
// sequencer state encoding and default fixed-point format.
package nn_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int FRAC_W_DEF = 8;

  // Activation select codes; code 3 falls back to identity.
  typedef enum logic [1:0] {
    ACT_IDENT = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_HSIG  = 2'd2
  } act_e;

  // Sequencer states.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    TAIL = 3'd2,
    ACT  = 3'd3,
    OUT  = 3'd4,
    DONE = 3'd5
  } state_t;

endpackage

// File: rtl/nn_act_unit.sv
// Per-lane output stage: round half up, saturate to DATA_W, then apply the
// selected activation. Purely combinational.
module nn_act_unit
  import nn_pkg::*;
#(
  parameter int ACC_W  = 42,
  parameter int DATA_W = DATA_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic        [1:0]        act,
  output logic        [DATA_W-1:0] result
);

  localparam logic signed [ACC_W-1:0]  SAT_MAX = (ACC_W'(1) <<< (DATA_W-1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0]  SAT_MIN = -SAT_MAX - ACC_W'(1);
  localparam logic signed [ACC_W-1:0]  RND     = ACC_W'(1 << (FRAC_W-1));
  localparam logic signed [DATA_W+1:0] HS_OFS  = (DATA_W+2)'(1 << (FRAC_W-1));
  localparam logic signed [DATA_W+1:0] HS_ONE  = (DATA_W+2)'(1 << FRAC_W);

  logic signed [ACC_W-1:0]  rounded;
  logic signed [DATA_W-1:0] sat_val;
  logic signed [DATA_W+1:0] hs;

  // Round, saturate and select the activation.
  always_comb begin
    rounded = (acc + RND) >>> FRAC_W;
    if (rounded > SAT_MAX)      sat_val = DATA_W'(SAT_MAX);
    else if (rounded < SAT_MIN) sat_val = DATA_W'(SAT_MIN);
    else                        sat_val = DATA_W'(rounded);

    hs = (DATA_W+2)'(sat_val >>> 2) + HS_OFS;

    result = sat_val;
    case (act)
      ACT_RELU: result = sat_val[DATA_W-1] ? '0 : sat_val;
      ACT_HSIG: begin
        if (hs[DATA_W+1])    result = '0;
        else if (hs > HS_ONE) result = DATA_W'(HS_ONE);
        else                  result = DATA_W'(hs);
      end
      default:  result = sat_val;
    endcase
  end

endmodule

// File: rtl/nn_layer_engine.sv
// Fully-connected layer engine: LANES MAC lanes sharing one weight stream,
// with an address sequencer and a valid/ready result port (one neuron per
// transfer, all lanes in parallel).
module nn_layer_engine
  import nn_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int FRAC_W    = FRAC_W_DEF,
  parameter int LANES     = 10,
  parameter int IN_ADDR_W = 10,
  parameter int N_ADDR_W  = 7,
  parameter int W_ADDR_W  = 18,
  parameter int ACC_W     = 2*DATA_W + IN_ADDR_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  input  logic [IN_ADDR_W:0]        cfg_n_inputs,
  input  logic [N_ADDR_W:0]         cfg_n_neurons,
  input  logic [1:0]                cfg_act,
  output logic [IN_ADDR_W-1:0]      in_addr,
  output logic [W_ADDR_W-1:0]       w_addr,
  output logic                      rd_en,
  input  logic [LANES*DATA_W-1:0]   in_data,
  input  logic [DATA_W-1:0]         w_data,
  output logic [LANES*DATA_W-1:0]   out_data,
  output logic [N_ADDR_W-1:0]       out_neuron,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      done
);

  state_t state, state_next;

  logic [IN_ADDR_W:0]       n_inputs;
  logic [N_ADDR_W:0]        n_neurons;
  logic [1:0]               act_sel;
  logic [N_ADDR_W-1:0]      neuron;
  logic                     rd_d1;
  logic                     last_input;
  logic                     last_neuron;

  logic signed [ACC_W-1:0]    acc     [LANES];
  logic signed [2*DATA_W-1:0] prod    [LANES];
  logic        [DATA_W-1:0]   act_res [LANES];

  assign last_input  = ({1'b0, in_addr} == n_inputs - (IN_ADDR_W+1)'(1));
  assign last_neuron = ({1'b0, neuron} == n_neurons - (N_ADDR_W+1)'(1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and control outputs; abort overrides every transition.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
    state_next = state;
    rd_en      = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = RUN;
      end
      RUN: begin
        rd_en = 1'b1;
        if (last_input) state_next = TAIL;
      end
      TAIL: state_next = ACT;
      ACT:  state_next = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = last_neuron ? DONE : RUN;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  // Signed lane products of the read-back sample and the shared weight.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      prod[k] = $signed(in_data[k*DATA_W +: DATA_W]) * $signed(w_data);
    end
  end

  // Sequencer counters, configuration latch, accumulators and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_inputs   <= '0;
      n_neurons  <= '0;
      act_sel    <= '0;
      in_addr    <= '0;
      w_addr     <= '0;
      neuron     <= '0;
      rd_d1      <= 1'b0;
      out_data   <= '0;
      out_neuron <= '0;
      // NOTE: the accumulators are individual flops, not a RAM, so resetting them is legal and cheap.
      for (int k = 0; k < LANES; k++) acc[k] <= '0;
    end else begin
      rd_d1 <= rd_en & ~abort;
      if (rd_d1) begin
        for (int k = 0; k < LANES; k++) acc[k] <= acc[k] + ACC_W'(prod[k]);
      end
      case (state)
        IDLE: begin
          if (start) begin
            n_inputs  <= (cfg_n_inputs == '0) ? (IN_ADDR_W+1)'(1) : cfg_n_inputs;
            n_neurons <= (cfg_n_neurons == '0) ? (N_ADDR_W+1)'(1) : cfg_n_neurons;
            act_sel   <= cfg_act;
            in_addr   <= '0;
            w_addr    <= '0;
            neuron    <= '0;
            for (int k = 0; k < LANES; k++) acc[k] <= '0;
          end
        end
        RUN: begin
          w_addr  <= w_addr + W_ADDR_W'(1);
          in_addr <= last_input ? '0 : in_addr + IN_ADDR_W'(1);
        end
        ACT: begin
          for (int k = 0; k < LANES; k++) out_data[k*DATA_W +: DATA_W] <= act_res[k];
          out_neuron <= neuron;
        end
        OUT: begin
          if (out_ready && !last_neuron) begin
            neuron  <= neuron + N_ADDR_W'(1);
            in_addr <= '0;
            for (int k = 0; k < LANES; k++) acc[k] <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // One output stage per lane.
  for (genvar k = 0; k < LANES; k++) begin : g_act
    nn_act_unit #(
      .ACC_W  (ACC_W),
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W)
    ) u_act (
      .acc    (acc[k]),
      .act    (act_sel),
      .result (act_res[k])
    );
  end

endmodule

// File: tb/tb_nn_layer_engine.sv
// Scoreboard bench for nn_layer_engine: an SRAM model answers reads, expected
// neuron results are queued at start and compared as each transfer completes.
module tb_nn_layer_engine;

  localparam int DW    = 16;
  localparam int LN    = 10;
  localparam int IAW   = 10;
  localparam int NAW   = 7;
  localparam int WAW   = 18;
  localparam int VW    = LN*DW;
  localparam int LIMIT = 200;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             abort;
  logic [IAW:0]     cfg_n_inputs;
  logic [NAW:0]     cfg_n_neurons;
  logic [1:0]       cfg_act;
  logic [IAW-1:0]   in_addr;
  logic [WAW-1:0]   w_addr;
  logic             rd_en;
  logic [VW-1:0]    in_data;
  logic [DW-1:0]    w_data;
  logic [VW-1:0]    out_data;
  logic [NAW-1:0]   out_neuron;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;

  nn_layer_engine dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .cfg_n_inputs  (cfg_n_inputs),
    .cfg_n_neurons (cfg_n_neurons),
    .cfg_act       (cfg_act),
    .in_addr       (in_addr),
    .w_addr        (w_addr),
    .rd_en         (rd_en),
    .in_data       (in_data),
    .w_data        (w_data),
    .out_data      (out_data),
    .out_neuron    (out_neuron),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            neuron;
    logic [VW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   rd_idx  = 0;
  int   cur_n_in = 1;
  bit   chk_addr = 1'b0;
  int   done_cnt = 0;

  logic signed [DW-1:0] in_mem [LN][64];
  logic signed [DW-1:0] w_mem  [64];

  bit             rd_pend = 1'b0;
  logic [IAW-1:0] pend_in;
  logic [WAW-1:0] pend_w;

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Fixed-point reference: round half up, saturate, activation.
  function automatic logic [DW-1:0] ref_act(input longint acc, input logic [1:0] a);
    longint r;
    r = (acc + 128) >>> 8;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    if (a == 2'd1) begin
      if (r < 0) r = 0;
    end else if (a == 2'd2) begin
      r = (r >>> 2) + 128;
      if (r < 0)   r = 0;
      if (r > 256) r = 256;
    end
    return DW'(r);
  endfunction

  // Input/weight SRAM model with one cycle of read latency; garbage otherwise.
  always @(negedge clk) begin
    if (rd_pend) begin
      for (int k = 0; k < LN; k++) in_data[k*DW +: DW] = in_mem[k][pend_in[5:0]];
      w_data = w_mem[pend_w[5:0]];
    end else begin
      for (int k = 0; k < LN; k++) in_data[k*DW +: DW] = DW'($urandom);
      w_data = DW'($urandom);
    end
    rd_pend = rd_en;
    pend_in = in_addr;
    pend_w  = w_addr;
    if (rd_en && chk_addr) begin
      check("in_addr", VW'(in_addr), VW'(rd_idx % cur_n_in));
      check("w_addr", VW'(w_addr), VW'(rd_idx));
      rd_idx++;
    end
  end

  // Scoreboard compare on every accepted transfer; done pulse counter.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected", VW'(1), VW'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_neuron", VW'(out_neuron), VW'(e.neuron));
        for (int k = 0; k < LN; k++)
          check($sformatf("lane%0d", k), VW'(out_data[k*DW +: DW]), VW'(e.data[k*DW +: DW]));
      end
    end
  end

  task automatic fill_rand();
    int v;
    for (int k = 0; k < LN; k++)
      for (int i = 0; i < 64; i++) begin
        v = int'($urandom_range(0, 2047)) - 1024;
        in_mem[k][i] = DW'(v);
      end
    for (int a = 0; a < 64; a++) begin
      v = int'($urandom_range(0, 2047)) - 1024;
      w_mem[a] = DW'(v);
    end
  endtask

  task automatic run_layer(input int n_in, input int n_neu, input logic [1:0] act,
                           input int stall, input bit poke);
    int   eff_in, eff_neu, cnt;
    exp_t e;
    logic [VW-1:0] snap;
    longint acc;
    eff_in  = (n_in == 0) ? 1 : n_in;
    eff_neu = (n_neu == 0) ? 1 : n_neu;
    for (int j = 0; j < eff_neu; j++) begin
      e.neuron = j;
      for (int k = 0; k < LN; k++) begin
        acc = 0;
        for (int i = 0; i < eff_in; i++)
          acc += longint'(in_mem[k][i]) * longint'(w_mem[j*eff_in + i]);
        e.data[k*DW +: DW] = ref_act(acc, act);
      end
      sb.push_back(e);
    end
    rd_idx        = 0;
    cur_n_in      = eff_in;
    chk_addr      = 1'b1;
    cfg_n_inputs  = (IAW+1)'(n_in);
    cfg_n_neurons = (NAW+1)'(n_neu);
    cfg_act       = act;
    start         = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cnt   = 0;
    check("busy_run", VW'(busy), VW'(1));
    if (poke) begin
      cfg_n_inputs  = (IAW+1)'(1);
      cfg_n_neurons = (NAW+1)'(5);
      cfg_act       = ~act;
      start         = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cnt   = 1;
    end
    for (int j = 0; j < eff_neu; j++) begin
      while (!out_valid && cnt < LIMIT) begin
        @(posedge clk); #1;
        cnt++;
      end
      check("latency", VW'(cnt), VW'(eff_in + 2));
      snap = out_data;
      repeat (stall) begin
        @(posedge clk); #1;
        check("stall_valid", VW'(out_valid), VW'(1));
        check("stall_rd_en", VW'(rd_en), VW'(0));
        check("stall_hold", out_data, snap);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      cnt = 0;
    end
    check("done_pulse", VW'(done), VW'(1));
    @(posedge clk); #1;
    check("done_low", VW'(done), VW'(0));
    check("idle", VW'(busy), VW'(0));
    check("read_count", VW'(rd_idx), VW'(eff_in * eff_neu));
    check("sb_drained", VW'(sb.size()), VW'(0));
    chk_addr = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0;
    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    cfg_n_inputs = '0; cfg_n_neurons = '0; cfg_act = '0;
    for (int k = 0; k < LN; k++)
      for (int i = 0; i < 64; i++) in_mem[k][i] = '0;
    for (int a = 0; a < 64; a++) w_mem[a] = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_busy", VW'(busy), VW'(0));
    check("rst_rd_en", VW'(rd_en), VW'(0));
    check("rst_valid", VW'(out_valid), VW'(0));
    check("rst_done", VW'(done), VW'(0));
    check("rst_addr", VW'({in_addr, w_addr}), VW'(0));
    check("rst_out", out_data, VW'(0));
    @(posedge clk); #1;

    // Identity with rounding corners.
    fill_rand();
    in_mem[0][0] = 16'sd256; in_mem[0][1] = 16'sd512;
    in_mem[1][0] = 16'sd0;   in_mem[1][1] = 16'sd1;
    in_mem[2][0] = 16'sd0;   in_mem[2][1] = -16'sd1;
    in_mem[3][0] = 16'sd0;   in_mem[3][1] = -16'sd3;
    w_mem[0] = 16'sd256;     w_mem[1] = 16'sd128;
    run_layer(2, 1, 2'd0, 0, 1'b0);

    // ReLU.
    fill_rand();
    in_mem[0][0] = -16'sd512; in_mem[1][0] = 16'sd300;
    w_mem[0] = 16'sd256;
    run_layer(1, 1, 2'd1, 0, 1'b0);

    // Hard-sigmoid centre, upper clamp, lower clamp.
    fill_rand();
    in_mem[0][0] = 16'sd0; in_mem[1][0] = 16'sd1024;
    in_mem[2][0] = -16'sd1024; in_mem[3][0] = -16'sd512;
    w_mem[0] = 16'sd256;
    run_layer(1, 1, 2'd2, 0, 1'b0);

    // Positive and negative saturation.
    for (int k = 0; k < LN; k++) for (int i = 0; i < 4; i++) in_mem[k][i] = 16'sd32767;
    for (int i = 0; i < 4; i++) w_mem[i] = 16'sd32767;
    run_layer(4, 1, 2'd0, 0, 1'b0);
    for (int k = 0; k < LN; k++) for (int i = 0; i < 4; i++) in_mem[k][i] = -16'sd32768;
    run_layer(4, 1, 2'd0, 0, 1'b0);

    // Backpressure and weight addressing across three neurons, code 3 = identity.
    fill_rand();
    run_layer(3, 3, 2'd3, 5, 1'b0);

    // Zero configuration behaves as one input, one neuron.
    fill_rand();
    run_layer(0, 0, 2'd0, 0, 1'b0);

    // Start pulsed during RUN is ignored.
    fill_rand();
    run_layer(6, 2, 2'd1, 1, 1'b1);

    // Abort in RUN: back to IDLE next edge, no done pulse.
    fill_rand();
    cfg_n_inputs = (IAW+1)'(8); cfg_n_neurons = (NAW+1)'(2); cfg_act = 2'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_pre_rd", VW'(rd_en), VW'(1));
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", VW'(busy), VW'(0));
    check("abort_rd_en", VW'(rd_en), VW'(0));
    check("abort_valid", VW'(out_valid), VW'(0));
    d0 = done_cnt;
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_done", VW'(done_cnt), VW'(d0));
    check("abort_still_idle", VW'({busy, out_valid}), VW'(0));

    // Reset asserted mid-ACT clears everything asynchronously.
    cfg_n_inputs = (IAW+1)'(2); cfg_n_neurons = (NAW+1)'(1); cfg_act = 2'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_busy", VW'(busy), VW'(1));
    reset = 1'b1;
    #1;
    check("mid_rst_busy", VW'(busy), VW'(0));
    check("mid_rst_ctrl", VW'({rd_en, out_valid, done}), VW'(0));
    check("mid_rst_addr", VW'({in_addr, w_addr}), VW'(0));
    check("mid_rst_out", out_data, VW'(0));
    check("mid_rst_neuron", VW'(out_neuron), VW'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    fill_rand();
    run_layer(3, 2, 2'd0, 2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
